mem_write_demux_4x4b: RTL and testbench



---
 rtl/mem_write_demux_pkg.sv | 8 +
 rtl/mem_write_demux_4x4b_decoder_2to4.sv | 9 +
 rtl/mem_write_demux_4x4b.sv | 88 ++++++++
 tb/tb_mem_write_demux_4x4b.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_write_demux_pkg.sv
// mem_write_demux_pkg: shared types and sizes for the 4x4-bit write demux
package mem_write_demux_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
  localparam int NUM_WORDS  = 4;
  localparam int ADDR_W     = 2;
  localparam int DATA_W     = 4;
  localparam int WCOUNT_MAX = 7;
endpackage

// File: rtl/mem_write_demux_4x4b_decoder_2to4.sv
// decoder_2to4: gated 2-bit to one-hot decode
// Ports: en_i gate, sel_i index, oh_o one-hot (all zero when en_i is low)
module decoder_2to4 (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] oh_o
);
  assign oh_o = en_i ? 4'b0001 << sel_i : 4'b0000;
endmodule

// File: rtl/mem_write_demux_4x4b.sv
// mem_write_demux_4x4b: val/rdy write demux into four 4-bit words with sequenced clear
// Ports: clk, rst (sync, active-high); wval/wrdy/waddr/wdata write request;
//   clr starts a 4-cycle clear, busy flags it; word0..word3 contents;
//   vmask per-word written flags; wcount saturating accepted-write count.
// Macro MEM_WRITE_DEMUX_WMASK_EN adds a per-bit write mask input wmask.
module mem_write_demux_4x4b
  import mem_write_demux_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wval,
  output logic              wrdy,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_WRITE_DEMUX_WMASK_EN
  input  logic [DATA_W-1:0] wmask,
`endif
  input  logic              clr,
  output logic              busy,
  output logic [DATA_W-1:0] word0,
  output logic [DATA_W-1:0] word1,
  output logic [DATA_W-1:0] word2,
  output logic [DATA_W-1:0] word3,
  output logic [NUM_WORDS-1:0] vmask,
  output logic [2:0]        wcount
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] word_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] vmask_q, wr_en, clr_en;
  logic [2:0] wcount_q, wcount_d;
  logic [DATA_W-1:0] bmask;
  logic start, fire;
`ifdef MEM_WRITE_DEMUX_WMASK_EN
  assign bmask = wmask;
`else
  assign bmask = '1;
`endif
  assign start = (state_q == IDLE) && clr;
  assign fire  = wval && wrdy;
  decoder_2to4 u_wr_dec  (.en_i(fire), .sel_i(waddr),     .oh_o(wr_en));
  decoder_2to4 u_clr_dec (.en_i(busy), .sel_i(clr_idx_q), .oh_o(clr_en));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  always_comb begin
    state_d   = start ? CLEAR : (state_q == CLEAR && clr_idx_q == 2'd3) ? IDLE : state_q;
    clr_idx_d = (state_q == CLEAR) ? clr_idx_q + 2'd1 : '0;
    wcount_d  = start ? 3'd0 : !fire ? wcount_q : (wcount_q == 3'(WCOUNT_MAX)) ? wcount_q : wcount_q + 3'd1;
  end
  // clr takes priority over a same-cycle write, so wrdy depends on clr combinationally
  always_comb begin
    wrdy = (state_q == IDLE) && !clr;
    busy = (state_q == CLEAR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) word_q[i] <= RESET_VAL;
      vmask_q  <= '0;
      wcount_q <= '0;
    end else begin
      wcount_q <= wcount_d;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (clr_en[i]) begin
          word_q[i]  <= RESET_VAL;
          vmask_q[i] <= 1'b0;
        end else if (wr_en[i]) begin
          word_q[i]  <= (word_q[i] & ~bmask) | (wdata & bmask);
          vmask_q[i] <= vmask_q[i] | (|bmask);
        end
      end
    end
  end
  assign word0  = word_q[0];
  assign word1  = word_q[1];
  assign word2  = word_q[2];
  assign word3  = word_q[3];
  assign vmask  = vmask_q;
  assign wcount = wcount_q;
endmodule

// File: tb/tb_mem_write_demux_4x4b.sv
// tb_mem_write_demux_4x4b: directed self-checking bench for mem_write_demux_4x4b
module tb_mem_write_demux_4x4b;
  logic clk = 0, rst, wval, clr;
  logic [1:0] waddr;
  logic [3:0] wdata, wmask;
  logic wrdy, busy;
  logic [3:0] word0, word1, word2, word3, vmask;
  logic [2:0] wcount;
  logic [15:0] words;
  int n_cmp = 0, n_err = 0;
  assign words = {word3, word2, word1, word0};
  always #5 clk = ~clk;
  mem_write_demux_4x4b dut (
    .clk(clk), .rst(rst), .wval(wval), .wrdy(wrdy), .waddr(waddr), .wdata(wdata),
`ifdef MEM_WRITE_DEMUX_WMASK_EN
    .wmask(wmask),
`endif
    .clr(clr), .busy(busy), .word0(word0), .word1(word1), .word2(word2), .word3(word3),
    .vmask(vmask), .wcount(wcount)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    wval = 1; waddr = a; wdata = d;
    step();
    wval = 0;
  endtask
  initial begin
    rst = 1; wval = 0; clr = 0; waddr = 0; wdata = 0; wmask = 4'hF;
    step();
    rst = 0;
    chk("rst_words", words, 16'h0000);
    chk("rst_vmask", 16'(vmask), 16'h0);
    chk("rst_wcount", 16'(wcount), 16'h0);
    chk("rst_wrdy", 16'(wrdy), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    wr(2'd0, 4'hA);
    chk("wr0_words", words, 16'h000A);
    wr(2'd2, 4'h5);
    chk("wr2_words", words, 16'h050A);
    wr(2'd3, 4'hF);
    chk("wr3_words", words, 16'hF50A);
    chk("wr3_vmask", 16'(vmask), 16'hD);
    chk("wr3_wcount", 16'(wcount), 16'h3);
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 9; i++) wr(2'd1, 4'(i));
    chk("sat_words", words, 16'h0080);
    chk("sat_vmask", 16'(vmask), 16'h2);
    chk("sat_wcount", 16'(wcount), 16'h7);
    wr(2'd0, 4'hC);
    wr(2'd2, 4'h6);
    wr(2'd3, 4'h9);
    chk("pre_clr_words", words, 16'h968C);
    chk("pre_clr_wcount", 16'(wcount), 16'h7);
    clr = 1; wval = 1; waddr = 2'd0; wdata = 4'h3;
    #1;
    chk("coll_wrdy", 16'(wrdy), 16'h0);
    step();
    clr = 0;
    chk("clr0_busy", 16'(busy), 16'h1);
    chk("clr0_wrdy", 16'(wrdy), 16'h0);
    chk("clr0_wcount", 16'(wcount), 16'h0);
    chk("clr0_words", words, 16'h968C);
    step();
    chk("clr1_words", words, 16'h9680);
    chk("clr1_vmask", 16'(vmask), 16'hE);
    chk("clr1_busy", 16'(busy), 16'h1);
    clr = 1;
    step();
    chk("clr2_words", words, 16'h9600);
    chk("clr2_vmask", 16'(vmask), 16'hC);
    clr = 0;
    step();
    chk("clr3_words", words, 16'h9000);
    chk("clr3_busy", 16'(busy), 16'h1);
    step();
    chk("clr4_words", words, 16'h0000);
    chk("clr4_vmask", 16'(vmask), 16'h0);
    chk("clr4_busy", 16'(busy), 16'h0);
    chk("clr4_wrdy", 16'(wrdy), 16'h1);
    chk("clr4_wcount", 16'(wcount), 16'h0);
    step();
    wval = 0;
    chk("held_words", words, 16'h0003);
    chk("held_vmask", 16'(vmask), 16'h1);
    chk("held_wcount", 16'(wcount), 16'h1);
    wr(2'd3, 4'hF);
    clr = 1;
    step();
    clr = 0;
    step();
    chk("mid_words", words, 16'hF000);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_wrdy", 16'(wrdy), 16'h1);
    chk("midrst_words", words, 16'h0000);
    chk("midrst_vmask", 16'(vmask), 16'h0);
    step();
    chk("midrst_idle_busy", 16'(busy), 16'h0);
`ifdef MEM_WRITE_DEMUX_WMASK_EN
    wr(2'd2, 4'hF);
    wmask = 4'b0101;
    wr(2'd2, 4'h0);
    chk("wm_word2", 16'(word2), 16'hA);
    wmask = 4'b0000;
    wr(2'd3, 4'h7);
    chk("wm_word3", 16'(word3), 16'h0);
    chk("wm_vmask", 16'(vmask), 16'h4);
    chk("wm_wcount", 16'(wcount), 16'h3);
    wmask = 4'hF;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
